// File: rtl/car_lane_ctrl_pkg.sv
// Shared game-field constants for the road section: screen size,
// lane start positions, per-lane base speeds and lane state codes.
package car_lane_ctrl_pkg;

    localparam int GAME_SCREEN_W = 640;
    localparam int GAME_MAX_LEVEL = 7;

    // Packed per lane, lane k at bits [k*10 +: 10].
    localparam logic [39:0] LANE_INIT_X = {
        10'd300, 10'd200, 10'd100, 10'd0
    };
    localparam logic [39:0] LANE_BASE_SPEED = {
        10'd4, 10'd3, 10'd2, 10'd1
    };

    localparam logic [1:0] ST_RUN = 2'd0;
    localparam logic [1:0] ST_PAUSED = 2'd1;
    localparam logic [1:0] ST_FROZEN = 2'd2;

    // Even lanes travel right, odd lanes travel left.
    function automatic bit lane_left(input int k);
        return (k % 2) == 1;
    endfunction

endpackage

// File: rtl/car_lane_ctrl_tick_divider.sv
// Free-running movement tick divider, counting 0..TICK_DIV-1.
// Ports: CLK, RST, i_clear (restart to 0), o_tick_cyc (count at top).
module car_lane_ctrl_tick_divider #(
    parameter int TICK_DIV = 250000
) (
    input  logic CLK,
    input  logic RST,
    input  logic i_clear,
    output logic o_tick_cyc
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] cnt;

    assign o_tick_cyc = (cnt == CW'(TICK_DIV - 1));

    always_ff @(posedge CLK) begin
        if (RST || i_clear || o_tick_cyc) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/car_lane_ctrl.sv
// Multi-lane car position controller with wrap, level speed, pause, freeze.
// Ports: CLK, RST, i_enable, i_level_up, i_restart, i_freeze,
//        o_car_x (packed lanes), o_level, o_tick, o_frozen.
module car_lane_ctrl
    import car_lane_ctrl_pkg::*;
#(
    parameter int NUM_LANES = 4,
    parameter int X_W = 10,
    parameter int SCREEN_W = GAME_SCREEN_W,
    parameter int TICK_DIV = 250000,
    parameter int MAX_LEVEL = GAME_MAX_LEVEL,
    parameter int FREEZE_TICKS = 100,
    parameter logic [NUM_LANES*X_W-1:0] INIT_X = LANE_INIT_X,
    parameter logic [NUM_LANES*X_W-1:0] BASE_SPEED = LANE_BASE_SPEED
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     i_enable,
    input  logic                     i_level_up,
    input  logic                     i_restart,
    input  logic                     i_freeze,
    output logic [NUM_LANES*X_W-1:0] o_car_x,
    output logic [2:0]               o_level,
    output logic                     o_tick,
    output logic                     o_frozen
);

    localparam int FW = $clog2(FREEZE_TICKS + 1);

    logic                     tick_cyc;
    logic [FW-1:0]            frz_cnt;
    logic [1:0]               state;
    logic                     move;
    logic [NUM_LANES*X_W-1:0] nxt_x;

    car_lane_ctrl_tick_divider #(
        .TICK_DIV(TICK_DIV)
    ) u_tick_divider (
        .CLK       (CLK),
        .RST       (RST),
        .i_clear   (i_restart),
        .o_tick_cyc(tick_cyc)
    );

    // Pause wins over freeze; both block movement.
    always_comb begin
        state = ST_RUN;
        if (!i_enable) begin
            state = ST_PAUSED;
        end else if (frz_cnt != '0) begin
            state = ST_FROZEN;
        end
    end

    assign move = tick_cyc && (state == ST_RUN);
    assign o_frozen = (frz_cnt != '0);

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        logic [X_W-1:0] x;
        logic [X_W-1:0] step;
        assign x = o_car_x[k*X_W +: X_W];
        assign step = BASE_SPEED[k*X_W +: X_W] + X_W'(o_level) - X_W'(1);
        if (lane_left(k)) begin : g_left
            // Wrapped result is below SCREEN_W, so X_W-bit modular math is exact.
            assign nxt_x[k*X_W +: X_W] = (x < step)
                ? x + X_W'(SCREEN_W) - step
                : x - step;
        end else begin : g_right
            logic [X_W:0] s;
            assign s = {1'b0, x} + {1'b0, step};
            assign nxt_x[k*X_W +: X_W] = (s >= (X_W+1)'(SCREEN_W))
                ? x + step - X_W'(SCREEN_W)
                : s[X_W-1:0];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            o_car_x <= INIT_X;
            o_level <= 3'd1;
            frz_cnt <= '0;
            o_tick  <= 1'b0;
        end else begin
            o_tick <= tick_cyc && !i_restart;
            if (i_restart) begin
                o_car_x <= INIT_X;
                o_level <= 3'd1;
                frz_cnt <= '0;
            end else begin
                if (i_level_up && (o_level != 3'(MAX_LEVEL))) begin
                    o_level <= o_level + 3'd1;
                end
                if (i_freeze) begin
                    frz_cnt <= FW'(FREEZE_TICKS);
                end else begin
                    if (tick_cyc && (frz_cnt != '0)) begin
                        frz_cnt <= frz_cnt - 1'b1;
                    end
                    if (move) begin
                        o_car_x <= nxt_x;
                    end
                end
            end
        end
    end

endmodule

// File: doc/car_lane_ctrl.md
# car_lane_ctrl

Parametrised multi-lane car position controller for the road section of the game field. It generalises fixed four-car, right-only movement to NUM_LANES lanes with alternating direction, explicit screen-width wrap, level-scaled speed, pause and a timed freeze. Outputs feed the sprite renderer and collision checker.

## Interface
- NUM_LANES, 4: number of lanes, one car per lane.
- X_W, 10: position width, in bits.
- SCREEN_W, 640: horizontal wrap modulus, in pixels.
- TICK_DIV, 250000: CLK cycles per movement tick.
- MAX_LEVEL, 7: level saturation value.
- FREEZE_TICKS, 100: ticks for which cars are held after i_freeze.
- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- i_enable  in  1  high = cars move on ticks; low = paused.
- i_level_up  in  1  one-cycle pulse: increment level.
- i_restart  in  1  one-cycle pulse: restore initial positions and level 1.
- i_freeze  in  1  one-cycle pulse: hold cars for FREEZE_TICKS ticks.
- o_car_x  out  NUM_LANES*X_W  packed positions; lane k is at bits [k*X_W +: X_W].
- o_level  out  3  current level, range 1..MAX_LEVEL.
- o_tick  out  1  one-cycle pulse per movement tick.
- o_frozen  out  1  high while the freeze count is non-zero.

## Operation
- Reset values: o_car_x lane k = INIT_X[k]; o_level = 1; divider = 0; freeze count = 0; o_tick = 0; o_frozen = 0.
- Divider: counts 0..TICK_DIV-1, then returns to 0. It is free-running and unaffected by i_enable.
- Tick: the tick cycle is the cycle in which the divider equals TICK_DIV-1. o_tick is registered, so it goes high the cycle after that, and the period is exactly TICK_DIV cycles.
- Step: step[k] = BASE_SPEED[k] + o_level - 1. Requirement: step < SCREEN_W for all levels.
- Direction: even lanes move right (+), odd lanes move left (-).
- Right wrap: s = x + step, computed X_W+1 bits wide. If s >= SCREEN_W, x <= s - SCREEN_W; otherwise x <= s.
- Left wrap: if x < step, x <= x + SCREEN_W - step; otherwise x <= x - step.
- All positions always stay within 0..SCREEN_W-1.
- Movement: on a tick cycle, all lanes update together only if i_enable = 1 and the freeze count = 0.
- Freeze: i_freeze loads FREEZE_TICKS into the freeze count. The count decrements by 1 on each tick cycle while it is non-zero.
  - Freeze while already frozen reloads FREEZE_TICKS.
  - Freeze on a tick cycle loads the count; no move and no decrement occur that cycle.
  - o_frozen = (freeze count != 0).
- Level: i_level_up increments o_level and saturates at MAX_LEVEL. Level-up on a tick cycle: that move uses the old level.
- Restart:
  - Positions reload to INIT_X. Level = 1, freeze count = 0, divider = 0.
  - No move that cycle.
  - The first subsequent tick comes TICK_DIV cycles later.
- Priority: RST > i_restart > i_freeze > movement. i_level_up is ignored on a restart cycle.
- States: RUN (enable=1, freeze=0), PAUSED (enable=0), FROZEN (freeze≠0).
  - PAUSED takes precedence for movement. The freeze count still decrements in PAUSED.
  - Transitions are purely combinational on enable and the freeze count.

## Timing
- Position update latency: one cycle. The new o_car_x is visible on the cycle following the tick cycle, aligned with o_tick = 1.
- Control pulses are sampled every cycle; the effect is visible on the next cycle.
- Reset mid-tick discards any pending move. The divider restarts from 0.
- i_enable deasserted on the tick cycle: no move. Reasserted mid-period: the next move is on the next natural tick.

## Structure
- Shared constants include holds SCREEN_W, INIT_X[], BASE_SPEED[], MAX_LEVEL and lane direction, alongside the existing game constants.
- One sub-module: tick_divider (params TICK_DIV; ports CLK, RST, i_clear, o_tick_cyc).
- The per-lane wrap adder is a generate loop, not a sub-module.

## Test plan
Bench parameters: TICK_DIV=4, SCREEN_W=640, FREEZE_TICKS=2, INIT_X={0,100,200,300}, BASE_SPEED={1,2,3,4}.
1. Reset, enable=1, run 3 ticks -> lane0 = 3, lane1 = 94, lane2 = 209, lane3 = 288; o_tick period exactly 4 cycles.
2. Force lane0 to 639 via INIT_X=639 with level 1; one tick -> 0. Lane1 at x=1, step 2 -> 639.
3. 8 i_level_up pulses -> o_level = 7 (saturated). Next tick lane0 step = 7.
4. i_freeze, then 2 ticks -> no position change and o_frozen = 1. Third tick moves cars; o_frozen drops after the 2nd tick.
5. i_restart coincident with i_level_up and a tick cycle -> positions = INIT_X, o_level = 1, no move, next o_tick 4 cycles later.
6. enable = 0 for 3 ticks -> positions unchanged, o_tick still pulses. RST mid-period -> all outputs return to their reset values next cycle.
